// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder.
package mem_responder_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic FAULT_SA0 = 1'b0;
    localparam logic FAULT_SA1 = 1'b1;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/mem_rd_pipe.sv
// Read data delay line: DEPTH-deep shift register, cleared on reset or flush.
module mem_rd_pipe #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] stage_q [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (en) begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: scrubbed array, pipelined reads, saturating access counters.
// Define FAULT_INJECT_EN to enable read-data corruption at fault_addr.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned   AW       = 8,
    parameter int unsigned   DW       = 8,
    parameter int unsigned   RD_LAT   = 1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wra,
    input  logic [DW-1:0]    wrd,
    input  logic [AW-1:0]    rda,
    output logic [DW-1:0]    rdd,
    output logic             busy,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count,
    input  logic             fault_en,
    input  logic [AW-1:0]    fault_addr,
    input  logic [DW-1:0]    fault_mask,
    input  logic             fault_type
);

    localparam int unsigned DEPTH = 1 << AW;

    if (RD_LAT == 0 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_responder: RD_LAT must be in 1..4");
    end

    state_e           state_q, state_d;
    logic [AW-1:0]    scrub_ptr_q, scrub_ptr_d;
    logic [CNT_W-1:0] wr_count_q, wr_count_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;

    logic [DW-1:0] mem [DEPTH];
    logic          ready;
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] pipe_din;

    assign ready = (state_q == ST_READY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_INIT;
            scrub_ptr_q <= '0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            scrub_ptr_q <= scrub_ptr_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        scrub_ptr_d = scrub_ptr_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        unique case (state_q)
            ST_INIT: begin
                scrub_ptr_d = scrub_ptr_q + 1'b1;
                if (scrub_ptr_q == {AW{1'b1}}) state_d = ST_READY;
            end
            ST_READY: begin
                if (we && wr_count_q != CNT_MAX) wr_count_d = wr_count_q + 1'b1;
                // rda is sampled every ready cycle, so each one counts as a read
                if (rd_count_q != CNT_MAX) rd_count_d = rd_count_q + 1'b1;
            end
        endcase
    end

    // Scrub owns the write port until the array is fully initialised
    assign mem_we = !ready || we;
    assign mem_wa = ready ? wra : scrub_ptr_q;
    assign mem_wd = ready ? wrd : INIT_VAL;

    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Combinational read of the pre-edge contents gives read-before-write ordering
    assign rd_data = mem[rda];

`ifdef FAULT_INJECT_EN
    always_comb begin
        pipe_din = rd_data;
        if (fault_en && rda == fault_addr) begin
            pipe_din = (fault_type == FAULT_SA1) ? (rd_data | fault_mask)
                                                 : (rd_data & ~fault_mask);
        end
    end
`else
    logic unused_fault;
    assign unused_fault = ^{fault_en, fault_addr, fault_mask, fault_type};
    assign pipe_din     = rd_data;
`endif

    mem_rd_pipe #(
        .DW    (DW),
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clock (clock),
        .reset (reset),
        .flush (!ready),
        .en    (ready),
        .din   (pipe_din),
        .dout  (rdd)
    );

    assign busy     = !ready;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (RD_LAT=1 and RD_LAT=3 instances).
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [7:0]  wra = '0, wrd = '0, rda = '0;
    logic        fault_en = 1'b0, fault_type = 1'b0;
    logic [7:0]  fault_addr = '0, fault_mask = '0;
    logic [7:0]  rdd1, rdd3;
    logic        busy1, busy3;
    logic [15:0] wrc1, rdc1, wrc3, rdc3;

    int checks = 0;
    int failures = 0;
    int n;

    always #5 clock = ~clock;

    mem_responder #(.AW(8), .DW(8), .RD_LAT(1), .INIT_VAL(8'h00)) u_dut1 (
        .clock(clock), .reset(reset), .we(we), .wra(wra), .wrd(wrd), .rda(rda),
        .rdd(rdd1), .busy(busy1), .wr_count(wrc1), .rd_count(rdc1),
        .fault_en(fault_en), .fault_addr(fault_addr), .fault_mask(fault_mask),
        .fault_type(fault_type)
    );

    mem_responder #(.AW(8), .DW(8), .RD_LAT(3), .INIT_VAL(8'h00)) u_dut3 (
        .clock(clock), .reset(reset), .we(we), .wra(wra), .wrd(wrd), .rda(rda),
        .rdd(rdd3), .busy(busy3), .wr_count(wrc3), .rd_count(rdc3),
        .fault_en(fault_en), .fault_addr(fault_addr), .fault_mask(fault_mask),
        .fault_type(fault_type)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Call at the negedge where reset is released; returns busy cycles observed.
    task automatic wait_scrub(output int cnt);
        cnt = 0;
        while (busy1 && cnt < 1000) begin
            @(negedge clock);
            cnt++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst_busy", busy1, 1);
        check("rst_rdd", rdd1, 8'h00);
        check("rst_wrc", wrc1, 0);
        check("rst_rdc", rdc1, 0);
        repeat (2) @(negedge clock);

        // 1: scrub length, writes ignored while busy, array cleared
        we = 1'b1; wra = 8'h00; wrd = 8'hFF;
        reset = 1'b1;
        wait_scrub(n);
        we = 1'b0;
        check("scrub_len", n, 256);
        check("scrub_len3", busy3, 0);
        check("scrub_wrc", wrc1, 0);
        check("scrub_rdc", rdc1, 0);
        for (int a = 0; a < 256; a++) begin
            rda = a[7:0];
            @(negedge clock);
            check($sformatf("init_rd_%02h", a), rdd1, 8'h00);
        end
        check("sweep_rdc", rdc1, 256);

        // 2: latency 1 and 3
        rda = 8'h00;
        repeat (4) @(negedge clock);
        we = 1'b1; wra = 8'h10; wrd = 8'hA5;
        @(negedge clock);
        we = 1'b0; rda = 8'h10;
        @(negedge clock);
        check("lat1_rdd", rdd1, 8'hA5);
        check("lat3_t1", rdd3, 8'h00);
        rda = 8'h00;
        @(negedge clock);
        check("lat1_next", rdd1, 8'h00);
        check("lat3_t2", rdd3, 8'h00);
        @(negedge clock);
        check("lat3_t3", rdd3, 8'hA5);
        @(negedge clock);
        check("lat3_t4", rdd3, 8'h00);

        // 3: same-cycle write/read returns old data
        we = 1'b1; wra = 8'h20; rda = 8'h20; wrd = 8'h5A;
        @(negedge clock);
        check("rbw_old", rdd1, 8'h00);
        we = 1'b0;
        @(negedge clock);
        check("rbw_new", rdd1, 8'h5A);

        // 4: fault injection
        we = 1'b1; wra = 8'h41; wrd = 8'hFF; rda = 8'h00;
        @(negedge clock);
        we = 1'b0;
        fault_en = 1'b1; fault_addr = 8'h40; fault_mask = 8'h01; fault_type = 1'b1;
        rda = 8'h40;
        @(negedge clock);
`ifdef FAULT_INJECT_EN
        check("fault_sa1", rdd1, 8'h01);
`else
        check("fault_sa1", rdd1, 8'h00);
`endif
        rda = 8'h41;
        @(negedge clock);
        check("fault_other", rdd1, 8'hFF);
        fault_addr = 8'h41; fault_mask = 8'h0F; fault_type = 1'b0;
        @(negedge clock);
`ifdef FAULT_INJECT_EN
        check("fault_sa0", rdd1, 8'hF0);
`else
        check("fault_sa0", rdd1, 8'hFF);
`endif
        fault_en = 1'b0;
        @(negedge clock);
        check("fault_stored", rdd1, 8'hFF);
        we = 1'b1; wra = 8'hF0; wrd = 8'h77;
        @(negedge clock);
        we = 1'b0; rda = 8'hF0;
        @(negedge clock);
        check("hi_addr_rd", rdd1, 8'h77);
        check("wrc_4", wrc1, 4);
        check("wrc3_4", wrc3, 4);

        // 5: reset in the middle of a scrub restarts it from address 0
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (128) @(negedge clock);
        check("mid_busy_pre", busy1, 1);
        reset = 1'b0;
        #1;
        check("mid_busy", busy1, 1);
        check("mid_wrc", wrc1, 0);
        check("mid_rdc", rdc1, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        wait_scrub(n);
        check("rescrub_len", n, 256);
        check("rescrub_wrc", wrc1, 0);
        rda = 8'hF0;
        @(negedge clock);
        check("rescrub_hi", rdd1, 8'h00);
        rda = 8'h10;
        @(negedge clock);
        check("rescrub_lo", rdd1, 8'h00);

        // 6: counter saturation
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        wait_scrub(n);
        check("sat_scrub", n, 256);
        we = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            wra = i[7:0]; wrd = i[7:0];
            @(negedge clock);
        end
        check("wrc_fffe", wrc1, 16'hFFFE);
        check("rdc_fffe", rdc1, 16'hFFFE);
        repeat (6) @(negedge clock);
        check("wrc_sat", wrc1, 16'hFFFF);
        check("rdc_sat", rdc1, 16'hFFFF);
        check("wrc3_sat", wrc3, 16'hFFFF);
        we = 1'b0;
        repeat (3) @(negedge clock);
        check("wrc_hold", wrc1, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
